// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and Wishbone cycle/burst encodings for the round-robin arbiter
package wb_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  // Index width that stays legal for a single-master build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// rtl/wb_arb_rr_pick.sv - combinational round-robin picker: first requester after last_grant, wrapping
module wb_arb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic               valid,
  output logic [IW-1:0]      index
);

  int          cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    valid    = 1'b0;
    index    = '0;
    cand     = 0;
    cand_idx = '0;
    // last_grant itself is searched last, so a lone requester can win again.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(last_grant) + i) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// rtl/wb_arbiter_rr.sv - N-master to 1-slave Wishbone B3 round-robin arbiter
// Optional bus watchdog enabled by defining WB_ARB_WATCHDOG_EN.
module wb_arbiter_rr
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n_i,
  input  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i,
  input  logic [NUM_MASTERS*(DW/8)-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]        wbm_we_i,
  input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]      wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]      wbm_bte_i,
  output logic [NUM_MASTERS*DW-1:0]     wbm_dat_o,
  output logic [NUM_MASTERS-1:0]        wbm_ack_o,
  output logic [NUM_MASTERS-1:0]        wbm_err_o,
  output logic [NUM_MASTERS-1:0]        wbm_rty_o,
  output logic [AW-1:0]                 wbs_adr_o,
  output logic [DW-1:0]                 wbs_dat_o,
  output logic [DW/8-1:0]               wbs_sel_o,
  output logic                          wbs_we_o,
  output logic                          wbs_cyc_o,
  output logic                          wbs_stb_o,
  output logic [2:0]                    wbs_cti_o,
  output logic [1:0]                    wbs_bte_o,
  input  logic [DW-1:0]                 wbs_dat_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i
);

  localparam int SW = DW / 8;
  localparam int IW = idx_width(NUM_MASTERS);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          owned, owner_cyc, arb_en, stb_raw, wd_fire;

  assign owned     = (state_q == ARB_OWNED);
  assign owner_cyc = wbm_cyc_i[owner_q];
  // Re-arbitrate whenever the bus is free, including the cycle the owner lets go.
  assign arb_en    = !owned || !owner_cyc;

  wb_arb_rr_pick #(.NUM_REQ(NUM_MASTERS), .IW(IW)) u_pick (
    .req        (wbm_cyc_i),
    .last_grant (last_q),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (arb_en) begin
      if (pick_valid) begin
        state_d = ARB_OWNED;
        owner_d = pick_idx;
        last_d  = pick_idx;
      end else begin
        state_d = ARB_IDLE;
      end
    end
  end

  assign stb_raw   = owned && wbm_stb_i[owner_q];
  assign wbs_stb_o = stb_raw && !wd_fire;
  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    if (owned) begin
      wbs_adr_o = wbm_adr_i[owner_q*AW +: AW];
      wbs_dat_o = wbm_dat_i[owner_q*DW +: DW];
      wbs_sel_o = wbm_sel_i[owner_q*SW +: SW];
      wbs_we_o  = wbm_we_i[owner_q];
      wbs_cyc_o = owner_cyc;
      wbs_cti_o = wbm_cti_i[owner_q*3 +: 3];
      wbs_bte_o = wbm_bte_i[owner_q*2 +: 2];
      wbm_ack_o[owner_q] = wbs_ack_i;
      wbm_err_o[owner_q] = wbs_err_i || wd_fire;
      wbm_rty_o[owner_q] = wbs_rty_i;
    end
  end

`ifdef WB_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt;
  logic          slv_term;

  assign slv_term = owned && (wbs_ack_i || wbs_err_i || wbs_rty_i);
  // Fires on the TIMEOUT_CYCLES-th stalled strobe; any real termination that cycle wins.
  assign wd_fire  = stb_raw && !slv_term && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wd_cnt <= '0;
    end else if (arb_en || slv_term || wd_fire) begin
      wd_cnt <= '0;
    end else if (stb_raw) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

endmodule
